// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, filters `locked`, and releases a clean fabric reset.
// Optional bounded-retry FAIL state is enabled by defining PLL_SUP_RETRY_LIMIT_EN.
module pll_lock_supervisor #(
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int CNT_W          = 8,
  parameter int RETRY_MAX      = 4
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             clr,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic             timeout_err,
  output logic             fail
);

  localparam int TMR_A   = (LOCK_FILTER > LOCK_TIMEOUT) ? LOCK_FILTER : LOCK_TIMEOUT;
  localparam int TMR_MAX = (TMR_A > PLL_RST_CYCLES) ? TMR_A : PLL_RST_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  // The timer holds "remaining cycles minus one", so a load of N gives N cycles.
  localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] FLT_LOAD = TMR_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

`ifdef PLL_SUP_RETRY_LIMIT_EN
  localparam int RTY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;
  typedef enum logic [2:0] {S_PLL_RESET, S_WAIT_LOCK, S_FILTER, S_RUN, S_FAIL} state_t;
  logic [RTY_W-1:0] retry_reg, retry_next;
`else
  typedef enum logic [1:0] {S_PLL_RESET, S_WAIT_LOCK, S_FILTER, S_RUN} state_t;
`endif

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [1:0]       sync_reg;
  logic             lk;
  logic             timeout_evt, loss_evt;
  logic             pll_rst_reg, pll_rst_next;
  logic             run_reg, run_next;
  logic             fail_reg, fail_next;
  logic [CNT_W-1:0] lock_loss_reg, timeout_cnt_reg;
  logic             timeout_err_reg;

  assign lk = sync_reg[1];

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    retry_next  = retry_reg;
`endif
    case (state_reg)
      S_PLL_RESET: begin
        if (timer_reg == '0) begin
          state_next = S_WAIT_LOCK;
          timer_next = TO_LOAD;
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_next = S_FILTER;
          timer_next = FLT_LOAD;
        end else if (timer_reg == '0) begin
          timeout_evt = 1'b1;
          state_next  = S_PLL_RESET;
          timer_next  = RST_LOAD;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          if (retry_reg == RTY_W'(RETRY_MAX - 1)) begin
            state_next = S_FAIL;
          end else begin
            retry_next = retry_reg + RTY_W'(1);
          end
`endif
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      S_FILTER: begin
        // Any glitch restarts the whole acquisition window, not just the filter.
        if (!lk) begin
          state_next = S_WAIT_LOCK;
          timer_next = TO_LOAD;
        end else if (timer_reg == '0) begin
          state_next = S_RUN;
`ifdef PLL_SUP_RETRY_LIMIT_EN
          retry_next = '0;
`endif
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      S_RUN: begin
        if (!lk) begin
          loss_evt   = 1'b1;
          state_next = S_PLL_RESET;
          timer_next = RST_LOAD;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    run_next     = (state_next == S_RUN);
    pll_rst_next = (state_next == S_PLL_RESET);
    fail_next    = 1'b0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
    if (state_next == S_FAIL) begin
      pll_rst_next = 1'b1;
      fail_next    = 1'b1;
    end
`endif
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg        <= '0;
      state_reg       <= S_PLL_RESET;
      timer_reg       <= RST_LOAD;
      pll_rst_reg     <= 1'b1;
      run_reg         <= 1'b0;
      fail_reg        <= 1'b0;
      lock_loss_reg   <= '0;
      timeout_cnt_reg <= '0;
      timeout_err_reg <= 1'b0;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      retry_reg       <= '0;
`endif
    end else begin
      sync_reg    <= {sync_reg[0], pll_locked};
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      pll_rst_reg <= pll_rst_next;
      run_reg     <= run_next;
      fail_reg    <= fail_next;
`ifdef PLL_SUP_RETRY_LIMIT_EN
      retry_reg   <= retry_next;
`endif
      // clr wins over a same-cycle increment; the FSM never sees clr.
      if (clr) begin
        lock_loss_reg   <= '0;
        timeout_cnt_reg <= '0;
        timeout_err_reg <= 1'b0;
      end else begin
        if (loss_evt && lock_loss_reg != CNT_SAT) lock_loss_reg <= lock_loss_reg + CNT_W'(1);
        if (timeout_evt && timeout_cnt_reg != CNT_SAT) timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
        if (timeout_evt) timeout_err_reg <= 1'b1;
      end
    end
  end

  assign pll_rst       = pll_rst_reg;
  assign sys_rst_n     = run_reg;
  assign ready         = run_reg;
  assign lock_loss_cnt = lock_loss_reg;
  assign timeout_cnt   = timeout_cnt_reg;
  assign timeout_err   = timeout_err_reg;
`ifdef PLL_SUP_RETRY_LIMIT_EN
  assign fail          = fail_reg;
`else
  // Retries are unbounded here, so RETRY_MAX never limits anything.
  assign fail          = fail_reg && (RETRY_MAX > 0);
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; timeline indices count negedges since rst_n release.
module tb_pll_lock_supervisor;

  localparam int CNT_W = 4;

  logic             refclk = 1'b0;
  logic             rst_n, pll_locked, clr;
  logic             pll_rst, sys_rst_n, ready, timeout_err, fail;
  logic [CNT_W-1:0] lock_loss_cnt, timeout_cnt;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  int b = 0;
  int cnt = 0;
  int t = 0;
  int ll_exp = 0;

  pll_lock_supervisor #(
    .LOCK_FILTER(8), .LOCK_TIMEOUT(100), .PLL_RST_CYCLES(4), .CNT_W(CNT_W), .RETRY_MAX(3)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .clr(clr),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready),
    .lock_loss_cnt(lock_loss_cnt), .timeout_cnt(timeout_cnt),
    .timeout_err(timeout_err), .fail(fail)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(negedge refclk);
    n++;
  endtask

  task automatic goto(input int k);
    while (n < k) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @%0d: observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ready === 1'b1) break;
      tick();
    end
    check("ready_within_budget", ready, 1);
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    rst_n = 1'b0; pll_locked = 1'b0; clr = 1'b0;
    repeat (3) @(negedge refclk);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_lock_loss", lock_loss_cnt, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_fail", fail, 0);

    // Test 1: power-up acquire, lock raised 10 cycles after release.
    rst_n = 1'b1; n = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(pll_rst);
      tick();
    end
    check("t1_pll_rst_width", cnt, 4);
    goto(10); pll_locked = 1'b1;
    goto(20); check("t1_sys_rst_n_early", sys_rst_n, 0); check("t1_ready_early", ready, 0);
    goto(21); check("t1_sys_rst_n", sys_rst_n, 1); check("t1_ready", ready, 1);
    check("t1_pll_rst", pll_rst, 0); check("t1_lock_loss", lock_loss_cnt, 0);
    check("t1_timeout_cnt", timeout_cnt, 0); check("t1_timeout_err", timeout_err, 0);

    // Test 3: one-cycle lock drop in RUN.
    goto(25); pll_locked = 1'b0;
    tick();   pll_locked = 1'b1;
    goto(27); check("t3_sys_rst_n_hold", sys_rst_n, 1);
    goto(28); check("t3_sys_rst_n_drop", sys_rst_n, 0); check("t3_ready_drop", ready, 0);
    check("t3_lock_loss", lock_loss_cnt, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(pll_rst);
      tick();
    end
    check("t3_pll_rst_width", cnt, 4);
    goto(40); check("t3_rerelease_early", sys_rst_n, 0);
    goto(41); check("t3_rerelease", sys_rst_n, 1); check("t3_ready", ready, 1);

    // Test 4: glitch after 5 clean filter cycles restarts the filter.
    goto(42); pll_locked = 1'b0;
    goto(45); check("t4_loss_drop", sys_rst_n, 0); check("t4_lock_loss", lock_loss_cnt, 2);
    goto(50); pll_locked = 1'b1;
    goto(56); pll_locked = 1'b0;
    goto(57); pll_locked = 1'b1;
    goto(61); check("t4_no_release_unglitched", sys_rst_n, 0);
    goto(67); check("t4_no_release_early", sys_rst_n, 0);
    goto(68); check("t4_release", sys_rst_n, 1); check("t4_ready", ready, 1);
    check("t4_timeout_cnt", timeout_cnt, 0);

    // Test 2 / 6: lock held low, repeated timeouts.
    goto(70); pll_locked = 1'b0;
    goto(73); check("t2_lock_loss", lock_loss_cnt, 3);
    goto(77); check("t2_wait_pll_rst", pll_rst, 0);
`ifdef PLL_SUP_RETRY_LIMIT_EN
    for (int k = 1; k <= 3; k++) begin
      t = 177 + 104 * (k - 1);
      goto(t - 1); check("t6_cnt_before", timeout_cnt, k - 1); check("t6_fail_before", fail, 0);
      goto(t);     check("t6_cnt_after", timeout_cnt, k); check("t6_pll_rst_on", pll_rst, 1);
      check("t6_timeout_err", timeout_err, 1);
    end
    check("t6_fail", fail, 1);
    pll_locked = 1'b1;
    goto(420); check("t6_fail_held", fail, 1); check("t6_pll_rst_held", pll_rst, 1);
    check("t6_ready_held", ready, 0); check("t6_sys_rst_n_held", sys_rst_n, 0);
    rst_n = 1'b0; pll_locked = 1'b0;
    #1;
    check("t6_rst_fail", fail, 0); check("t6_rst_timeout_cnt", timeout_cnt, 0);
    check("t6_rst_lock_loss", lock_loss_cnt, 0);
    @(negedge refclk); rst_n = 1'b1; n = 0;
    goto(103); check("t6_retry_cnt_before", timeout_cnt, 0);
    goto(104); check("t6_retry_cnt_after", timeout_cnt, 1); check("t6_retry_fail", fail, 0);
    pll_locked = 1'b1;
    ll_exp = 0;
`else
    for (int k = 1; k <= 16; k++) begin
      t = 177 + 104 * (k - 1);
      goto(t - 1); check("t2_cnt_before", timeout_cnt, sat15(k - 1)); check("t2_pll_rst_off", pll_rst, 0);
      goto(t);     check("t2_cnt_after", timeout_cnt, sat15(k)); check("t2_pll_rst_on", pll_rst, 1);
      check("t2_timeout_err", timeout_err, 1); check("t2_fail", fail, 0);
      goto(t + 3); check("t2_pll_rst_last", pll_rst, 1);
      goto(t + 4); check("t2_pll_rst_end", pll_rst, 0);
    end
    pll_locked = 1'b1;
    ll_exp = 3;
`endif
    wait_ready(60);

    // Test 5: clr coincides with a lock-loss increment.
    b = n;
    check("t5_err_before", timeout_err, 1);
    check("t5_lock_loss_before", lock_loss_cnt, ll_exp);
    goto(b + 1); pll_locked = 1'b0;
    goto(b + 3); clr = 1'b1;
    goto(b + 4); clr = 1'b0;
    check("t5_lock_loss_cleared", lock_loss_cnt, 0); check("t5_err_cleared", timeout_err, 0);
    check("t5_timeout_cnt_cleared", timeout_cnt, 0);
    check("t5_sys_rst_n", sys_rst_n, 0); check("t5_pll_rst", pll_rst, 1);
    goto(b + 7); check("t5_pll_rst_last", pll_rst, 1);
    goto(b + 8); check("t5_pll_rst_end", pll_rst, 0); pll_locked = 1'b1;
    goto(b + 18); check("t5_release_early", sys_rst_n, 0);
    goto(b + 19); check("t5_release", sys_rst_n, 1);
    goto(b + 21); pll_locked = 1'b0;
    goto(b + 22); pll_locked = 1'b1;
    goto(b + 24); check("t5_loss_after_clr", lock_loss_cnt, 1); check("t5_drop_after_clr", sys_rst_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
